// File: rtl/encoder_8_to_3_seq.sv
// -----------------------------------------------------------------------------
// encoder_8_to_3_seq
//
// Sequential 8-to-3 encoder, the inverse of a 3-to-8 line decoder. A request
// vector (one-hot or multi-hot) is accepted over a valid/ready handshake, and
// the binary index of every set bit is then emitted, one index per output beat,
// in priority order. Feeding the emitted indices into a decoder reproduces the
// set bits one at a time.
//
// Parameters
//   MSB_FIRST  0: bit 0 serviced first, 1: bit 7 serviced first
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous reset, active-low
//   in_valid   in   1  req is valid this cycle
//   in_ready   out  1  block can accept a new vector
//   req        in   8  request vector; bit i set = index i requested
//   out_valid  out  1  out_idx/out_last/out_none/out_count are valid
//   out_ready  in   1  consumer accepts the current beat
//   out_idx    out  3  binary index of the serviced bit
//   out_last   out  1  final beat for the current vector
//   out_none   out  1  vector was all-zero; the beat carries no index
//   out_count  out  4  popcount (0..8) of the accepted vector
// -----------------------------------------------------------------------------
module encoder_8_to_3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       out_none,
    output logic [3:0] out_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [2:0] r_out_idx;
    logic       r_out_last;
    logic       r_out_none;
    logic [3:0] r_out_count;

    // Number of set bits; 4 bits wide so a full vector reads as 8, not 0.
    function automatic logic [3:0] f_popcount(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
        return cnt;
    endfunction

    // Index of the highest-priority set bit. The scan runs from the
    // lowest-priority end so the final match is the winner. Returns 0 for
    // an all-zero vector, which is exactly what the out_none beat carries.
    function automatic logic [2:0] f_pick_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = i[2:0];
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = i[2:0];
            end
        end
        return idx;
    endfunction

    logic       w_accept;
    logic       w_beat_done;
    logic [7:0] w_pending_next;
    logic [2:0] w_req_idx;
    logic [3:0] w_req_count;
    logic [2:0] w_next_idx;
    logic [3:0] w_next_count;

    assign w_accept     = in_valid & r_in_ready;
    assign w_beat_done  = r_out_valid & out_ready;

    // Pending vector after the current beat's bit is retired. For the
    // out_none beat pending is already zero, so clearing bit 0 is harmless.
    assign w_pending_next = r_pending & ~(8'b0000_0001 << r_out_idx);

    assign w_req_idx    = f_pick_idx(req);
    assign w_req_count  = f_popcount(req);
    assign w_next_idx   = f_pick_idx(w_pending_next);
    assign w_next_count = f_popcount(w_pending_next);

    // Beat contents are precomputed one cycle ahead (from req on accept, from
    // the post-retire pending on each completed beat) so every output comes
    // straight from a flop and holds naturally during a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= 8'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= 3'd0;
            r_out_last  <= 1'b0;
            r_out_none  <= 1'b0;
            r_out_count <= 4'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_state     <= ST_EMIT;
                r_pending   <= req;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_idx   <= w_req_idx;
                // A zero vector still produces one (terminal) beat.
                r_out_last  <= (w_req_count <= 4'd1);
                r_out_none  <= (req == 8'd0);
                r_out_count <= w_req_count;
            end
        end else begin
            if (w_beat_done) begin
                r_pending <= w_pending_next;
                if (r_out_last) begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_idx   <= 3'd0;
                    r_out_last  <= 1'b0;
                    r_out_none  <= 1'b0;
                    r_out_count <= 4'd0;
                end else begin
                    r_out_idx  <= w_next_idx;
                    r_out_last <= (w_next_count == 4'd1);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_none  = r_out_none;
    assign out_count = r_out_count;

endmodule
